pipe_hazard_ctrl: RTL and testbench

//  Sequencing controller for the IF/ID pipeline register and the 8-bit PC of the 16-bit-instruction pipeline.

---
 rtl/pipe_hazard_ctrl_if.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// master = datapath side (drives hazard sources, receives controls),
// slave  = controller side.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 4
);
  logic [15:0]       id_instr;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              branch_taken;
  logic              imem_ready;
  logic              pc_write;
  logic              pc_sel;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic [1:0]        ctrl_state;
  logic [15:0]       stall_cycles;

  modport master (
    output id_instr, ex_mem_read, ex_rd, branch_taken, imem_ready,
    input  pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble,
           ctrl_state, stall_cycles
  );

  modport slave (
    input  id_instr, ex_mem_read, ex_rd, branch_taken, imem_ready,
    output pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble,
           ctrl_state, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: IF/ID and PC sequencing for the 16-bit pipeline.
// Resolves load-use stalls, taken-branch flushes and imem wait states with
// zero-latency combinational controls and a small multi-cycle penalty FSM.
// Optional macro HAZ_PERF_CNT_EN builds a saturating count of cycles in
// which the PC was held; otherwise stall_cycles is tied to zero.
module pipe_hazard_ctrl #(
  parameter int REG_AW          = 4,
  parameter int RS_LSB          = 4,
  parameter int RT_LSB          = 0,
  parameter int FLUSH_CYCLES    = 1,
  parameter int LU_STALL_CYCLES = 1
) (
  input logic                clk,
  input logic                reset,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // Counter load values: cycles still to go after the triggering cycle.
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] STALL_INIT = 4'(LU_STALL_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] rs, rt;
  logic              lu;
  logic              pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble;

  assign rs = bus.id_instr[RS_LSB +: REG_AW];
  assign rt = bus.id_instr[RT_LSB +: REG_AW];
  // r0 is hard-wired zero, so a load into it never creates a dependency.
  assign lu = bus.ex_mem_read & (bus.ex_rd != {REG_AW{1'b0}}) &
              ((bus.ex_rd == rs) | (bus.ex_rd == rt));

  // Next-state and control outputs; priority branch > imem wait > stall > normal.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    pc_sel       = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (reset) begin
      state_d      = ST_RUN;
      cnt_d        = 4'd0;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (bus.branch_taken) begin
      pc_sel       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      if (FLUSH_INIT == 4'd0) begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end else begin
        state_d = ST_FLUSH;
        cnt_d   = FLUSH_INIT;
      end
    end else if (!bus.imem_ready) begin
      // Freeze the front end; STALL/FLUSH penalties are paused, not consumed.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = (state_q == ST_FLUSH);
      case (state_q)
        ST_RUN, ST_WAIT: state_d = ST_WAIT;
        default:         state_d = state_q;
      endcase
    end else begin
      case (state_q)
        ST_RUN, ST_WAIT: begin
          state_d = ST_RUN;
          if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (STALL_INIT != 4'd0) begin
              state_d = ST_STALL;
              cnt_d   = STALL_INIT;
            end else begin
              cnt_d   = 4'd0;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          cnt_d        = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_STALL;
          end
        end
        ST_FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          cnt_d        = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // FSM state and penalty counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.pc_sel       = pc_sel;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.ctrl_state   = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_write && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Performance counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= 16'h0000;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
`else
  assign bus.stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: two instances (1/1 and 3/3
// penalty cycles) share directed stimulus; a penalty-bookkeeping model is
// compared every cycle, plus hand-computed literal expectations.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] id_instr;
  logic        ex_mem_read;
  logic [3:0]  ex_rd;
  logic        branch_taken;
  logic        imem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl_if #(.REG_AW(4)) i1 ();
  pipe_hazard_ctrl_if #(.REG_AW(4)) i3 ();

  assign i1.id_instr = id_instr;     assign i3.id_instr = id_instr;
  assign i1.ex_mem_read = ex_mem_read; assign i3.ex_mem_read = ex_mem_read;
  assign i1.ex_rd = ex_rd;           assign i3.ex_rd = ex_rd;
  assign i1.branch_taken = branch_taken; assign i3.branch_taken = branch_taken;
  assign i1.imem_ready = imem_ready; assign i3.imem_ready = imem_ready;

  pipe_hazard_ctrl #(.REG_AW(4), .RS_LSB(4), .RT_LSB(0),
                     .FLUSH_CYCLES(1), .LU_STALL_CYCLES(1))
    u_d1 (.clk(clk), .reset(reset), .bus(i1));

  pipe_hazard_ctrl #(.REG_AW(4), .RS_LSB(4), .RT_LSB(0),
                     .FLUSH_CYCLES(3), .LU_STALL_CYCLES(3))
    u_d3 (.clk(clk), .reset(reset), .bus(i3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Per instance: remaining extra penalty cycles and whether fetch is waiting.
  int fl_cyc[2] = '{1, 3};
  int lu_cyc[2] = '{1, 3};
  int flush_left[2] = '{0, 0};
  int stall_left[2] = '{0, 0};
  int waiting[2]    = '{0, 0};
  int perf[2]       = '{0, 0};

  function automatic bit lu_now();
    logic [3:0] rs_f, rt_f;
    rs_f = id_instr[7:4];
    rt_f = id_instr[3:0];
    return ex_mem_read && (ex_rd != 4'd0) && ((ex_rd == rs_f) || (ex_rd == rt_f));
  endfunction

  // {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble}
  function automatic logic [4:0] exp_ctl(int k);
    if (reset)                 return 5'b00011;
    if (branch_taken)          return 5'b11111;
    if (!imem_ready)           return {3'b000, flush_left[k] > 0, 1'b1};
    if (stall_left[k] > 0)     return 5'b00001;
    if (flush_left[k] > 0)     return 5'b10111;
    if (lu_now())              return 5'b00001;
    return 5'b10100;
  endfunction

  function automatic logic [1:0] exp_state(int k);
    if (flush_left[k] > 0) return 2'd2;
    if (stall_left[k] > 0) return 2'd1;
    if (waiting[k] != 0)   return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [15:0] exp_perf(int k);
`ifdef HAZ_PERF_CNT_EN
    return 16'(perf[k]);
`else
    return 16'h0000;
`endif
  endfunction

  // Model advance on each clock edge (and instantly on reset).
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      logic [4:0] c;
      if (reset) begin
        flush_left[k] = 0; stall_left[k] = 0; waiting[k] = 0; perf[k] = 0;
      end else begin
        c = exp_ctl(k);
        if (!c[4] && perf[k] < 65535) perf[k] = perf[k] + 1;
        if (branch_taken) begin
          flush_left[k] = fl_cyc[k] - 1; stall_left[k] = 0; waiting[k] = 0;
        end else if (!imem_ready) begin
          if (flush_left[k] == 0 && stall_left[k] == 0) waiting[k] = 1;
        end else if (stall_left[k] > 0) begin
          stall_left[k] = stall_left[k] - 1;
        end else if (flush_left[k] > 0) begin
          flush_left[k] = flush_left[k] - 1;
        end else begin
          waiting[k] = 0;
          if (lu_now()) stall_left[k] = lu_cyc[k] - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ctl1();
    return {i1.pc_write, i1.pc_sel, i1.if_id_write, i1.if_id_flush, i1.id_ex_bubble};
  endfunction

  function automatic logic [4:0] ctl3();
    return {i3.pc_write, i3.pc_sel, i3.if_id_write, i3.if_id_flush, i3.id_ex_bubble};
  endfunction

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    chk("d1 ctl",   32'(ctl1()),          32'(exp_ctl(0)));
    chk("d1 state", 32'(i1.ctrl_state),   32'(exp_state(0)));
    chk("d1 perf",  32'(i1.stall_cycles), 32'(exp_perf(0)));
    chk("d3 ctl",   32'(ctl3()),          32'(exp_ctl(1)));
    chk("d3 state", 32'(i3.ctrl_state),   32'(exp_state(1)));
    chk("d3 perf",  32'(i3.stall_cycles), 32'(exp_perf(1)));
  end

  task automatic drive(input logic [15:0] ins, input logic mr, input logic [3:0] rd,
                       input logic br, input logic rdy);
    @(posedge clk); #1;
    id_instr = ins; ex_mem_read = mr; ex_rd = rd; branch_taken = br; imem_ready = rdy;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(16'h0000, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; id_instr = 16'h0000; ex_mem_read = 1'b0; ex_rd = 4'd0;
    branch_taken = 1'b0; imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("lit reset ctl d1",   32'(ctl1()), 32'h03);
    chk("lit reset state d3", 32'(i3.ctrl_state), 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    idle();
    chk("lit normal d1", 32'(ctl1()), 32'h14);

    // T1 load-use on rs
    drive(16'h1230, 1'b1, 4'd3, 1'b0, 1'b1);
    chk("lit T1 lu d1", 32'(ctl1()), 32'h01);
    chk("lit T1 lu d3", 32'(ctl3()), 32'h01);
    idle();
    chk("lit T1 after d1", 32'(ctl1()), 32'h14);
    chk("lit T1 stall st d3", 32'(i3.ctrl_state), 32'h1);
    idle();
    chk("lit T1 stall2 d3", 32'(ctl3()), 32'h01);
    idle();
    chk("lit T1 resume d3", 32'(ctl3()), 32'h14);

    // T2 r0 never hazards
    drive(16'h1200, 1'b1, 4'd0, 1'b0, 1'b1);
    chk("lit T2 d1", 32'(ctl1()), 32'h14);
    drive(16'h1200, 1'b1, 4'd0, 1'b0, 1'b1);
    chk("lit T2 d3", 32'(ctl3()), 32'h14);

    // load-use via rt field
    drive(16'h0035, 1'b1, 4'd5, 1'b0, 1'b1);
    chk("lit rt lu d1", 32'(ctl1()), 32'h01);
    repeat (3) idle();

    // T3 branch beats lu and imem wait
    drive(16'h1230, 1'b1, 4'd3, 1'b1, 1'b0);
    chk("lit T3 d1", 32'(ctl1()), 32'h1F);
    chk("lit T3 d3", 32'(ctl3()), 32'h1F);

    // T4 three-cycle flush, then a restart mid-flush
    idle();
    chk("lit T4 st d3 c1", 32'(i3.ctrl_state), 32'h2);
    chk("lit T4 ctl d3 c1", 32'(ctl3()), 32'h17);
    chk("lit T4 st d1 c1", 32'(i1.ctrl_state), 32'h0);
    idle();
    chk("lit T4 st d3 c2", 32'(i3.ctrl_state), 32'h2);
    idle();
    chk("lit T4 st d3 c3", 32'(i3.ctrl_state), 32'h0);
    drive(16'h0000, 1'b0, 4'd0, 1'b1, 1'b1);
    idle();
    drive(16'h0000, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("lit T4 rebranch d3", 32'(ctl3()), 32'h1F);
    idle();
    chk("lit T4 re st c1", 32'(i3.ctrl_state), 32'h2);
    idle();
    chk("lit T4 re st c2", 32'(i3.ctrl_state), 32'h2);
    idle();
    chk("lit T4 re st c3", 32'(i3.ctrl_state), 32'h0);

    // imem wait inside a flush pauses the penalty
    drive(16'h0000, 1'b0, 4'd0, 1'b1, 1'b1);
    drive(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("lit flushwait d3", 32'(ctl3()), 32'h03);
    chk("lit flushwait d1", 32'(ctl1()), 32'h01);
    idle();
    chk("lit flushwait st d1", 32'(i1.ctrl_state), 32'h3);
    idle();
    chk("lit flushwait held d3", 32'(i3.ctrl_state), 32'h2);
    idle();
    chk("lit flushwait end d3", 32'(i3.ctrl_state), 32'h0);

    // T5 three wait cycles from a clean reset, then lu while leaving WAIT
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    drive(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("lit T5 st d1", 32'(i1.ctrl_state), 32'h3);
    drive(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("lit T5 pcw d1", 32'(i1.pc_write), 32'h0);
    drive(16'h1230, 1'b1, 4'd3, 1'b0, 1'b1);
`ifdef HAZ_PERF_CNT_EN
    chk("lit T5 perf d1", 32'(i1.stall_cycles), 32'd3);
`else
    chk("lit T5 perf d1", 32'(i1.stall_cycles), 32'd0);
`endif
    chk("lit T5 wait lu d1", 32'(ctl1()), 32'h01);

    // T6 reset in the second STALL cycle of the 3-cycle instance
    idle();
    chk("lit T6 stall1 d3", 32'(i3.ctrl_state), 32'h1);
    idle();
    chk("lit T6 stall2 d3", 32'(i3.ctrl_state), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("lit T6 async st d3", 32'(i3.ctrl_state), 32'h0);
    chk("lit T6 async ctl d3", 32'(ctl3()), 32'h03);
    @(posedge clk); #1 reset = 1'b0;
    idle();
    chk("lit T6 after d3", 32'(ctl3()), 32'h14);
    repeat (2) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
